// File: rtl/clk_mon_pkg.sv
// Shared types and defaults for the divided-clock frequency/duty monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam int EXP_PERIOD_D = 5;
  localparam int LOCK_COUNT_D = 4;
  localparam int TIMEOUT_D    = 20;
  localparam int CNT_W_D      = 8;

  // Allowed high time for a period: floor(period/2) .. ceil(period/2).
  function automatic int hi_bound(input int period, input bit upper);
    return upper ? (period + 1) / 2 : period / 2;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with asynchronous active-low reset.
module sync_2ff (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make both flops sample together, so d
  // really takes two edges to reach q; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of mon_clk in clk cycles, reports lock after
// a run of good periods and raises sticky period/duty/stall errors.
module clk_div_monitor
  import clk_mon_pkg::*;
#(
  parameter int EXP_PERIOD = EXP_PERIOD_D,
  parameter int LOCK_COUNT = LOCK_COUNT_D,
  parameter int TIMEOUT    = TIMEOUT_D,
  parameter int CNT_W      = CNT_W_D
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             mon_clk,
  input  logic             err_clr,
  output logic             lock,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             err_period,
  output logic             err_duty,
  output logic             err_stall
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);
  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] EXP_P   = CNT_W'(EXP_PERIOD);
  localparam logic [CNT_W-1:0] HI_MIN  = CNT_W'(hi_bound(EXP_PERIOD, 1'b0));
  localparam logic [CNT_W-1:0] HI_MAX  = CNT_W'(hi_bound(EXP_PERIOD, 1'b1));

  logic              mon_sync;
  logic              mon_dly;
  logic              rise;
  logic [CNT_W-1:0]  per_cnt;
  logic [CNT_W-1:0]  hi_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic              timeout;
  logic              per_ok;
  logic              duty_ok;
  state_t            state, state_nxt;
  logic [GOOD_W-1:0] good_cnt, good_nxt;
  logic              meas_fire;
  logic              set_period;
  logic              set_duty;
  logic              set_stall;

  sync_2ff u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (mon_clk),
    .q    (mon_sync)
  );

  assign rise    = mon_sync & ~mon_dly;
  assign timeout = !rise && (idle_cnt == IDLE_W'(TIMEOUT - 1));
  assign per_ok  = (per_cnt == EXP_P);
  assign duty_ok = (hi_cnt >= HI_MIN) && (hi_cnt <= HI_MAX);

  // Measurement counters; each rise closes one period and starts the next.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mon_dly  <= 1'b0;
      per_cnt  <= '0;
      hi_cnt   <= '0;
      idle_cnt <= '0;
    end else begin
      mon_dly <= mon_sync;
      if (rise)                    per_cnt <= CNT_W'(1);
      else if (per_cnt != CNT_MAX) per_cnt <= per_cnt + CNT_W'(1);
      if (rise)                                hi_cnt <= CNT_W'(1);
      else if (mon_sync && hi_cnt != CNT_MAX)  hi_cnt <= hi_cnt + CNT_W'(1);
      if (rise)                                  idle_cnt <= '0;
      else if (idle_cnt != IDLE_W'(TIMEOUT))     idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_nxt;
      good_cnt <= good_nxt;
    end
  end

  // NOTE: defaults first so every path assigns every output -- no latches.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    case (state)
      SEARCH: begin
        if (rise) begin
          state_nxt = MEASURE;
          good_nxt  = '0;
        end
      end
      MEASURE: begin
        if (timeout) begin
          state_nxt = SEARCH;
        end else if (rise) begin
          if (per_ok && duty_ok) begin
            good_nxt = good_cnt + GOOD_W'(1);
            if (good_cnt == GOOD_W'(LOCK_COUNT - 1)) state_nxt = LOCKED;
          end else begin
            good_nxt = '0;
          end
        end
      end
      LOCKED: begin
        if (timeout) begin
          state_nxt = SEARCH;
        end else if (rise && !(per_ok && duty_ok)) begin
          state_nxt = MEASURE;
          good_nxt  = '0;
        end
      end
      default: state_nxt = SEARCH;
    endcase
  end

  always_comb begin
    lock       = (state == LOCKED);
    meas_fire  = rise && (state != SEARCH);
    set_period = meas_fire && !per_ok;
    set_duty   = meas_fire && !duty_ok;
    set_stall  = timeout && (state != SEARCH);
  end

  // Error flags are set-priority: a set in the same cycle as err_clr wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meas_valid  <= 1'b0;
      meas_period <= '0;
      meas_high   <= '0;
      err_period  <= 1'b0;
      err_duty    <= 1'b0;
      err_stall   <= 1'b0;
    end else begin
      meas_valid <= meas_fire;
      if (meas_fire) begin
        meas_period <= per_cnt;
        meas_high   <= hi_cnt;
      end
      err_period <= set_period | (err_period & ~err_clr);
      err_duty   <= set_duty   | (err_duty   & ~err_clr);
      err_stall  <= set_stall  | (err_stall  & ~err_clr);
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: mon_clk waveforms driven from clk,
// expected measurements queued per driven period and popped on meas_valid.
module tb_clk_div_monitor;
  import clk_mon_pkg::*;

  localparam int CNT_W = CNT_W_D;

  typedef struct {
    int period;
    int high;
  } meas_t;

  logic             clk = 1'b0;
  logic             rstn;
  logic             mon_clk;
  logic             err_clr;
  logic             lock;
  logic             meas_valid;
  logic [CNT_W-1:0] meas_period;
  logic [CNT_W-1:0] meas_high;
  logic             err_period;
  logic             err_duty;
  logic             err_stall;

  meas_t       exp_q[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] lock_hist;
  logic [31:0] valid_hist;
  logic [31:0] stall_hist;
  logic        lock_seen;

  always #5 clk = ~clk;

  clk_div_monitor #(
    .EXP_PERIOD (EXP_PERIOD_D),
    .LOCK_COUNT (LOCK_COUNT_D),
    .TIMEOUT    (TIMEOUT_D),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .mon_clk     (mon_clk),
    .err_clr     (err_clr),
    .lock        (lock),
    .meas_valid  (meas_valid),
    .meas_period (meas_period),
    .meas_high   (meas_high),
    .err_period  (err_period),
    .err_duty    (err_duty),
    .err_stall   (err_stall)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One mon_clk period: high for h cycles then low; index i is the negedge
  // count from the high edge, and the *_hist vectors capture outputs there.
  task automatic drive_period(input int p, input int h, input int clr_at = -1);
    exp_q.push_back('{p, h});
    lock_hist  = '0;
    valid_hist = '0;
    stall_hist = '0;
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      lock_hist[i]  = lock;
      valid_hist[i] = meas_valid;
      stall_hist[i] = err_stall;
      mon_clk = (i < h);
      err_clr = (i == clr_at);
    end
  endtask

  always @(negedge clk) begin
    meas_t e;
    if (rstn && meas_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_meas_valid", 32'(meas_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("meas_period", 32'(meas_period), e.period);
        check("meas_high", 32'(meas_high), e.high);
      end
    end
  end

  initial begin
    rstn    = 1'b0;
    mon_clk = 1'b0;
    err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lock", 32'(lock), 32'd0);
    check("rst_meas_valid", 32'(meas_valid), 32'd0);
    check("rst_meas_period", 32'(meas_period), 32'd0);
    check("rst_meas_high", 32'(meas_high), 32'd0);
    check("rst_errs", 32'({err_period, err_duty, err_stall}), 32'd0);
    rstn = 1'b1;

    // Ideal clock: lock appears 3 edges after the 5th high edge.
    drive_period(5, 3);
    check("search_rise_no_valid", 32'(valid_hist[3]), 32'd0);
    repeat (3) drive_period(5, 3);
    check("no_lock_before_5th", 32'(lock), 32'd0);
    drive_period(5, 3);
    check("lock_low_before_edge", 32'(lock_hist[2]), 32'd0);
    check("lock_rise_timing", 32'(lock_hist[3]), 32'd1);
    check("valid_one_cycle", 32'(valid_hist[4:3]), 32'd1);
    check("ideal_no_errs", 32'({err_period, err_duty, err_stall}), 32'd0);

    // One long period while locked.
    drive_period(6, 3);
    check("lock_held_in_long", 32'(lock), 32'd1);
    drive_period(5, 3);
    check("lock_before_bad", 32'(lock_hist[2]), 32'd1);
    check("lock_drop_bad", 32'(lock_hist[3]), 32'd0);
    check("err_period_set", 32'(err_period), 32'd1);
    check("err_duty_clean", 32'(err_duty), 32'd0);
    repeat (3) drive_period(5, 3);
    drive_period(5, 3);
    check("relock_low_before", 32'(lock_hist[2]), 32'd0);
    check("relock", 32'(lock_hist[3]), 32'd1);
    check("err_period_sticky", 32'(err_period), 32'd1);
    drive_period(5, 3, 1);
    check("err_clr_clears", 32'(err_period), 32'd0);
    check("err_clr_keeps_lock", 32'(lock_hist[4:0]), 32'h1f);

    // err_clr coincident with a bad rise: the set wins.
    drive_period(6, 3);
    drive_period(5, 3, 2);
    check("set_beats_clr", 32'(err_period), 32'd1);
    check("lock_drop_bad2", 32'(lock_hist[3]), 32'd0);

    // Relock, then hold mon_clk low inside a long final period.
    repeat (3) drive_period(5, 3);
    drive_period(26, 3);
    check("lock_before_stall", 32'(lock_hist[3]), 32'd1);
    check("lock_at_19", 32'(lock_hist[22]), 32'd1);
    check("lock_drop_stall", 32'(lock_hist[23]), 32'd0);
    check("stall_at_19", 32'(stall_hist[22]), 32'd0);
    check("stall_at_20", 32'(stall_hist[23]), 32'd1);
    check("stalled_period_unreported", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    drive_period(5, 3);
    check("search_after_stall", 32'(valid_hist[3]), 32'd0);
    check("err_stall_sticky", 32'(err_stall), 32'd1);

    // Reset while locked.
    repeat (3) drive_period(5, 3);
    drive_period(5, 3);
    check("lock_before_reset", 32'(lock_hist[3]), 32'd1);
    @(negedge clk);
    rstn    = 1'b0;
    mon_clk = 1'b0;
    exp_q.delete();
    #1;
    check("mid_rst_lock", 32'(lock), 32'd0);
    check("mid_rst_meas", 32'({meas_valid, meas_period, meas_high}), 32'd0);
    check("mid_rst_errs", 32'({err_period, err_duty, err_stall}), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    drive_period(5, 3);
    check("post_rst_no_valid", 32'(valid_hist[3]), 32'd0);
    repeat (3) drive_period(5, 3);
    check("post_rst_no_lock_yet", 32'(lock), 32'd0);
    drive_period(5, 3);
    check("post_rst_relock_low", 32'(lock_hist[2]), 32'd0);
    check("post_rst_relock", 32'(lock_hist[3]), 32'd1);

    // Correct period, high time 4: duty error only, never locks.
    @(negedge clk);
    rstn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    lock_seen = 1'b0;
    repeat (6) begin
      drive_period(5, 4);
      lock_seen = lock_seen | (|lock_hist);
    end
    check("duty_never_locks", 32'(lock_seen), 32'd0);
    check("duty_err_duty", 32'(err_duty), 32'd1);
    check("duty_err_period", 32'(err_period), 32'd0);
    check("duty_err_stall", 32'(err_stall), 32'd0);
    repeat (2) @(negedge clk);
    check("meas_high_holds", 32'(meas_high), 32'd4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

endmodule
